// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg
//   Shared constants for the VGA timing generator. The defaults describe
//   800x600@60 Hz with a 40 MHz pixel clock. The package also holds the
//   derived line/frame totals, the packed sync bundle and the clog2 helper
//   that sizes the counters.
package vga_timing_pkg;

    localparam int unsigned DEF_H_VIS  = 800;
    localparam int unsigned DEF_H_FP   = 40;
    localparam int unsigned DEF_H_SYNC = 128;
    localparam int unsigned DEF_H_BP   = 88;
    localparam int unsigned DEF_V_VIS  = 600;
    localparam int unsigned DEF_V_FP   = 1;
    localparam int unsigned DEF_V_SYNC = 4;
    localparam int unsigned DEF_V_BP   = 23;
    localparam bit          DEF_H_POL  = 1'b1;
    localparam bit          DEF_V_POL  = 1'b1;

    localparam int unsigned DEF_H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Raw (active-high, undelayed) sync/enable bundle carried by the delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    // Bits needed to hold 0..v-1. Never returns less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// vga_sync_delay
//   WIDTH x DEPTH shift register with an asynchronous active-low clear.
//   DEPTH = 0 is a straight wire.
//   Ports:
//     clk_i   clock
//     rst_ni  async active-low clear (all stages go to 0)
//     d_i     data in  [WIDTH-1:0]
//     q_o     data out [WIDTH-1:0], d_i delayed by DEPTH clocks
module vga_sync_delay #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign q_o = d_i;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stage_q <= '0;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing. The free-running h/v counters are the only state of
//   the raster. The sync and display-enable decodes are delayed by PIPE_DLY
//   so that they line up with the pixel generator's registered RGB. The
//   status strobes are not delayed and stay aligned with col/row.
//   Ports:
//     clk          pixel clock
//     rst_n        async active-low reset
//     enable       run raster; low forces counters to (0,0) and syncs idle
//     col, row     current h/v count, zero-extended to 32 bits
//     hsync,vsync  syncs with polarity H_POL/V_POL, delayed PIPE_DLY
//     de           display enable, delayed PIPE_DLY
//     line_start   h_cnt==0 (undelayed)
//     frame_start  h_cnt==0 && v_cnt==0 (undelayed)
//     vblank       v_cnt >= V_VIS (undelayed)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VIS    = DEF_H_VIS,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_VIS    = DEF_V_VIS,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          H_POL    = DEF_H_POL,
    parameter bit          V_POL    = DEF_V_POL,
    parameter int unsigned PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [31:0] col,
    output logic [31:0] row,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW    = clog2(H_TOT);
    localparam int unsigned VW    = clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

    // Parameter sanity, caught at elaboration.
    if (PIPE_DLY > 7) begin : g_err_dly
        $error("vga_timing_gen: PIPE_DLY must be 0..7");
    end
    if (H_VIS == 0 || V_VIS == 0 || H_SYNC == 0 || V_SYNC == 0) begin : g_err_zero
        $error("vga_timing_gen: visible area and sync widths must be non-zero");
    end
    if (H_VIS + H_FP + H_SYNC > H_TOT || V_VIS + V_FP + V_SYNC > V_TOT) begin : g_err_wrap
        $error("vga_timing_gen: sync region crosses the counter wrap");
    end
    if (HW >= 32 || VW >= 32) begin : g_err_width
        $error("vga_timing_gen: line/frame totals too large for 32-bit coordinates");
    end

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign col = {{(32-HW){1'b0}}, h_cnt_q};
    assign row = {{(32-VW){1'b0}}, v_cnt_q};

    // rst_n is folded in so that the undelayed outputs (and the PIPE_DLY=0
    // syncs) read inactive while reset is held, even though the counters
    // sit at (0,0), which would otherwise decode as a visible frame start.
    logic run;
    assign run = enable & rst_n;

    sync_t raw, dly;
    assign raw.hs = run && (col >= H_VIS + H_FP) && (col < H_VIS + H_FP + H_SYNC);
    assign raw.vs = run && (row >= V_VIS + V_FP) && (row < V_VIS + V_FP + V_SYNC);
    assign raw.de = run && (col < H_VIS) && (row < V_VIS);

    vga_sync_delay #(
        .WIDTH(3),
        .DEPTH(PIPE_DLY)
    ) u_dly (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   (raw),
        .q_o   (dly)
    );

    assign hsync = dly.hs ^ ~H_POL;
    assign vsync = dly.vs ^ ~V_POL;
    assign de    = dly.de;

    assign line_start  = run && (h_cnt_q == '0);
    assign frame_start = line_start && (v_cnt_q == '0);
    assign vblank      = (row >= V_VIS);

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic en [3];

    logic [31:0] col_o [3];
    logic [31:0] row_o [3];
    logic hs_o [3], vs_o [3], de_o [3], ls_o [3], fs_o [3], vb_o [3];

    int tests = 0;
    int fails = 0;

    // Per-instance geometry: 0 = default 800x600, 1 = small active-low
    // PIPE_DLY=3, 2 = small active-high PIPE_DLY=0.
    int HV[3] = '{800, 16, 16};
    int HF[3] = '{40, 4, 4};
    int HS[3] = '{128, 6, 6};
    int HB[3] = '{88, 5, 5};
    int VV[3] = '{600, 10, 10};
    int VF[3] = '{1, 2, 2};
    int VS[3] = '{4, 3, 3};
    int VB[3] = '{23, 2, 2};
    int HP[3] = '{1, 0, 1};
    int VP[3] = '{1, 0, 1};
    int DL[3] = '{1, 3, 0};

    vga_timing_gen u_a (
        .clk(clk), .rst_n(rst_n), .enable(en[0]),
        .col(col_o[0]), .row(row_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]), .de(de_o[0]),
        .line_start(ls_o[0]), .frame_start(fs_o[0]), .vblank(vb_o[0])
    );

    vga_timing_gen #(
        .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_VIS(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b0), .PIPE_DLY(3)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .enable(en[1]),
        .col(col_o[1]), .row(row_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]), .de(de_o[1]),
        .line_start(ls_o[1]), .frame_start(fs_o[1]), .vblank(vb_o[1])
    );

    vga_timing_gen #(
        .H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_VIS(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(0)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .enable(en[2]),
        .col(col_o[2]), .row(row_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]), .de(de_o[2]),
        .line_start(ls_o[2]), .frame_start(fs_o[2]), .vblank(vb_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: each raster is a linear pixel position within the
    // frame; h/v are its remainder/quotient by the line length. The delay
    // line is a history of raw {hs,vs,de} (hist[k] = value k+1 clocks ago).
    int pos [3];
    logic [2:0] hist [3][8];

    // Literal pins on the model (independent of the model arithmetic)
    int a_hs_cnt, a_de_cnt;
    int c_per, c_vb_cnt;
    bit c_seen, c_clean;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int ht, vt, h, v;
            bit run;
            logic [2:0] raw, dl;
            logic [69:0] exp, act;
            if (!rst_n) begin
                pos[d] = 0;
                for (int k = 0; k < 8; k++) hist[d][k] = 3'b000;
            end
            ht = HV[d] + HF[d] + HS[d] + HB[d];
            vt = VV[d] + VF[d] + VS[d] + VB[d];
            h = pos[d] % ht;
            v = pos[d] / ht;
            run = rst_n && en[d];
            raw[2] = run && h >= HV[d] + HF[d] && h < HV[d] + HF[d] + HS[d];
            raw[1] = run && v >= VV[d] + VF[d] && v < VV[d] + VF[d] + VS[d];
            raw[0] = run && h < HV[d] && v < VV[d];
            dl = (DL[d] == 0) ? raw : hist[d][DL[d]-1];
            exp = {32'(h), 32'(v), dl[2] ^ (HP[d] == 0), dl[1] ^ (VP[d] == 0), dl[0],
                   1'(run && h == 0), 1'(run && h == 0 && v == 0), 1'(v >= VV[d])};
            act = {col_o[d], row_o[d], hs_o[d], vs_o[d], de_o[d], ls_o[d], fs_o[d], vb_o[d]};
            chk($sformatf("model_dut%0d", d), act, exp);
            if (rst_n) begin
                for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = raw;
                pos[d] = en[d] ? (pos[d] + 1) % (ht * vt) : 0;
            end
        end

        // Default raster: hsync edges one clock after col 840 / 968.
        if (rst_n && row_o[0] < 600) begin
            if (col_o[0] == 840) chk("a_hs_pre_rise", 70'(hs_o[0]), 70'(0));
            if (col_o[0] == 841) chk("a_hs_rise", 70'(hs_o[0]), 70'(1));
            if (col_o[0] == 968) chk("a_hs_last", 70'(hs_o[0]), 70'(1));
            if (col_o[0] == 969) chk("a_hs_fall", 70'(hs_o[0]), 70'(0));
        end
        if (col_o[0] == 0) begin
            a_hs_cnt = 0;
            a_de_cnt = 0;
        end
        if (hs_o[0]) a_hs_cnt++;
        if (de_o[0]) a_de_cnt++;
        if (rst_n && col_o[0] == 900 && row_o[0] < 600) chk("a_de_width", 70'(a_de_cnt), 70'(800));
        if (rst_n && col_o[0] == 1055) chk("a_hs_width", 70'(a_hs_cnt), 70'(128));

        // Active-low, 3-clock delayed instance: edges 3 clocks after the event.
        if (rst_n) begin
            if (col_o[1] == 22) chk("b_hs_idle", 70'(hs_o[1]), 70'(1));
            if (col_o[1] == 23) chk("b_hs_active", 70'(hs_o[1]), 70'(0));
            if (row_o[1] == 12 && col_o[1] == 2) chk("b_vs_idle", 70'(vs_o[1]), 70'(1));
            if (row_o[1] == 12 && col_o[1] == 3) chk("b_vs_active", 70'(vs_o[1]), 70'(0));
        end

        // Zero-delay instance: vsync edge in the same cycle as (12,0).
        if (rst_n && en[2]) begin
            if (row_o[2] == 11 && col_o[2] == 30) chk("c_vs_pre", 70'(vs_o[2]), 70'(0));
            if (row_o[2] == 12 && col_o[2] == 0) chk("c_vs_rise", 70'(vs_o[2]), 70'(1));
        end
        if (!rst_n || !en[2]) c_clean = 0;
        c_per++;
        if (vb_o[2]) c_vb_cnt++;
        if (fs_o[2]) begin
            if (c_seen && c_clean) begin
                chk("c_frame_period", 70'(c_per), 70'(527));
                chk("c_vblank_len", 70'(c_vb_cnt), 70'(217));
            end
            c_seen = 1;
            c_clean = 1;
            c_per = 0;
            c_vb_cnt = 0;
        end
    end

    // One clock of stimulus; inputs change 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
        if (en[1]) en[1] = ($urandom_range(0, 399) != 0);
        else       en[1] = ($urandom_range(0, 1) == 1);
        en[2] = en[1];
    endtask

    task automatic wait_a(input int r, input int c, input int budget);
        int n;
        n = 0;
        while (!(row_o[0] == 32'(r) && col_o[0] == 32'(c)) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL wait_a: (%0d,%0d) not reached within %0d cycles", r, c, budget);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en[0] = 1'b1;
        en[1] = 1'b1;
        en[2] = 1'b1;
        a_hs_cnt = 0; a_de_cnt = 0;
        c_per = 0; c_vb_cnt = 0; c_seen = 0; c_clean = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_col", 70'(col_o[0]), 70'(0));
        chk("rst_hs_b_idle_high", 70'(hs_o[1]), 70'(1));
        chk("rst_de_c", 70'(de_o[2]), 70'(0));
        chk("rst_fs_c", 70'(fs_o[2]), 70'(0));
        chk("rst_ls_a", 70'(ls_o[0]), 70'(0));
        #1 rst_n = 1'b1;
        #1 chk("rel_fs_a", 70'({col_o[0], fs_o[0]}), 70'(1));

        // enable toggle on the default raster
        wait_a(3, 500, 8000);
        en[0] = 1'b0;
        step();
        chk("dis_pos_a", 70'({col_o[0], row_o[0]}), 70'(0));
        chk("dis_de_a", 70'({de_o[0], hs_o[0]}), 70'(0));
        repeat (4) step();
        chk("dis_held_a", 70'({col_o[0], row_o[0], ls_o[0]}), 70'(0));
        en[0] = 1'b1;
        #1 chk("reen_fs_a", 70'({col_o[0], row_o[0], fs_o[0]}), 70'(1));

        // async reset between edges at (10,900)
        wait_a(10, 900, 15000);
        #1 rst_n = 1'b0;
        #1 chk("arst_pos_a", 70'({col_o[0], row_o[0]}), 70'(0));
        chk("arst_out_a", 70'({hs_o[0], de_o[0], ls_o[0], vb_o[0]}), 70'(0));
        chk("arst_vs_b", 70'(vs_o[1]), 70'(1));
        repeat (3) step();
        #1 rst_n = 1'b1;
        #1 chk("arel_fs_a", 70'({col_o[0], row_o[0], fs_o[0]}), 70'(1));

        repeat (6000) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
